// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per FETCH phase over a
// valid/ready channel, captures the returned word and flags timeout/misalignment faults.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      state,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            fetch_busy,
  output logic            fetch_fault
);

  localparam logic [2:0] PH_FETCH     = 3'd0;
  localparam logic [2:0] PH_WRITEBACK = 3'd3;

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_REQ   = 3'd1;
  localparam logic [2:0] F_WAIT  = 3'd2;
  localparam logic [2:0] F_DONE  = 3'd3;
  localparam logic [2:0] F_FAULT = 3'd4;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]      fstate_q, fstate_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            misalign;

  assign misalign = (state == PH_WRITEBACK) && branch_taken && (branch_target[1:0] != 2'b00);

  always_comb begin
    fstate_d = fstate_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    case (fstate_q)
      F_IDLE: if (state == PH_FETCH) fstate_d = F_REQ;
      F_REQ: begin
        if (mem_req_ready) begin
          fstate_d = F_WAIT;
          cnt_d    = '0;
        end
      end
      // A response on the expiry cycle still wins over the timeout.
      F_WAIT: begin
        if (mem_rsp_valid) begin
          instr_d  = mem_rsp_data;
          fstate_d = F_DONE;
        end else if (cnt_q == TO_LAST) begin
          fstate_d = F_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      F_DONE:  if (state != PH_FETCH) fstate_d = F_IDLE;
      F_FAULT: fstate_d = F_FAULT;
      default: fstate_d = F_IDLE;
    endcase
    if (state == PH_WRITEBACK) begin
      if (misalign) fstate_d = F_FAULT;
      else          pc_d     = branch_taken ? branch_target : pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate_q <= F_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      fstate_q <= fstate_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_req_valid = (fstate_q == F_REQ);
  assign mem_req_addr  = pc_q;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign fetch_fault   = (fstate_q == F_FAULT);
  assign fetch_busy    = ((state == PH_FETCH) && (fstate_q != F_DONE)) || (fstate_q == F_FAULT);

endmodule
